benes_route_scheduler: RTL
==========================

BENES_ROUTE_SCHEDULER -- requirements
Module: benes_route_scheduler

Interface
REQ-001 Parameter REQ_NUM, default 2, number of requesters sharing the interconnect.
REQ-002 Parameter CFG_DEPTH, default 16, number of stored switch configurations; CFG_AW = clog2(CFG_DEPTH).
REQ-003 Parameter NET_LAT, default 3, cycles from select change until interconnect outputs reflect it.
REQ-004 Parameter LEN_W, default 8, width of the transfer length field.
REQ-005 clk  input  1  clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cfg_we  input  1  configuration table write strobe.
REQ-008 cfg_addr  input  CFG_AW  configuration entry index.
REQ-009 cfg_module_sel  input  [SWITCH_NUM-1:0] x STAGE_NUM  R2M switch settings to store.
REQ-010 cfg_slot_sel  input  [SWITCH_NUM-1:0] x STAGE_NUM  M2R switch settings to store.
REQ-011 req_valid  input  REQ_NUM  per-requester route request.
REQ-012 req_cfg_id  input  CFG_AW x REQ_NUM  requested configuration entry.
REQ-013 req_len  input  LEN_W x REQ_NUM  transfer length in cycles.
REQ-014 req_ready  output  REQ_NUM  one-hot grant, asserted only in IDLE.
REQ-015 o_module_select  output  [SWITCH_NUM-1:0] x STAGE_NUM  R2M select to interconnect.
REQ-016 o_slot_select  output  [SWITCH_NUM-1:0] x STAGE_NUM  M2R select to interconnect.
REQ-017 o_window  output  REQ_NUM  one-hot, marks cycles the granted requester drives data.
REQ-018 o_done  output  1  single-cycle completion pulse.
REQ-019 o_done_id  output  clog2(REQ_NUM)  requester index belonging to o_done.
REQ-020 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-021 States IDLE, APPLY, DRAIN; IDLE->APPLY on handshake, APPLY->DRAIN after len cycles, DRAIN->IDLE after NET_LAT cycles.
REQ-022 In IDLE, a round-robin arbiter shall assert req_ready to exactly one valid requester, starting search at the one after the last granted.
REQ-023 Handshake is req_valid&req_ready in cycle T; the granted id, cfg entry and length are latched at T.
REQ-024 o_module_select/o_slot_select shall take the table entry at T+1 and hold it until the next grant.
REQ-025 o_window[g] shall be high T+1..T+L, where L = req_len, and req_len = 0 is treated as L = 1.
REQ-026 DRAIN spans T+L+1..T+L+NET_LAT; o_done pulses with o_done_id = g at T+L+NET_LAT+1, the first IDLE cycle.
REQ-027 A new grant may occur in the same cycle as o_done; there is no overlap of grants.
REQ-028 A cfg_we to any entry, including the active one, affects only later grants; the selects already driven are unchanged.
REQ-029 A cfg_we and a grant to the same entry in the same cycle shall use the old contents.
REQ-030 req_valid deasserting while not granted is legal; a granted requester shall not be regranted before any other valid requester.

Reset
REQ-031 On rst_n low:
  - state goes to IDLE.
  - selects, o_window, o_done, o_done_id, o_busy and req_ready are all zero.
  - the round-robin pointer points to requester 0.
  - counters are cleared.
REQ-032 Reset mid-APPLY/DRAIN aborts the transfer without any o_done; the configuration table contents are undefined after reset.

Structure
REQ-033 SWITCH_NUM and STAGE_NUM come from FHE_ALU_PKG; a state enum and a route-request struct (cfg_id, len) shall be added to that package.
REQ-034 The round-robin arbiter shall be a sub-module named rr_arbiter (req, grant, advance).
REQ-035 The configuration table shall be a register array with a synchronous write and a read at grant.

Verification
REQ-036 Single request: entry 3 written with module select stage0 = 0x0001; req0 id 3, len 4 granted at T -> selects equal entry 3 at T+1, window0 high T+1..T+4, o_done (id 0) at T+8.
REQ-037 Contention: both requests valid continuously with len 2 -> grants alternate 0,1,0,1 with back-to-back grants at each o_done cycle.
REQ-038 len 0 -> window high exactly one cycle, o_done at T+5.
REQ-039 cfg_we to the active entry during APPLY -> selects unchanged until the next grant, which uses the new data.
REQ-040 rst_n low during DRAIN -> all outputs zero asynchronously, no o_done, and after release a req1 alone is granted first cycle.

Source files
------------

// File: rtl/fhe_alu_pkg.sv
// Shared definitions for the FHE ALU interconnect.
//   SWITCH_NUM / STAGE_NUM : Benes network geometry (switches per stage, stages)
//   sw_sel_t               : one full set of switch selects for the network
//   route_state_e          : route scheduler FSM states
//   route_req_t            : a route request as seen by the scheduler (cfg_id, len)
//   route_cfg_t            : one configuration-table entry (R2M + M2R selects)
// The route_req_t field widths bound the largest table index / length the
// scheduler can carry; scheduler parameters must not exceed them.
package fhe_alu_pkg;

    localparam int SWITCH_NUM = 16;
    localparam int STAGE_NUM  = 9;

    localparam int ROUTE_CFG_AW = 4;
    localparam int ROUTE_LEN_W  = 8;

    typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] sw_sel_t;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_APPLY = 2'd1,
        RS_DRAIN = 2'd2
    } route_state_e;

    typedef struct packed {
        logic [ROUTE_CFG_AW-1:0] cfg_id;
        logic [ROUTE_LEN_W-1:0]  len;
    } route_req_t;

    typedef struct packed {
        sw_sel_t module_sel;
        sw_sel_t slot_sel;
    } route_cfg_t;

    // $clog2 that never returns 0, so single-entry sizes still get a 1-bit field
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/benes_route_scheduler_if.sv
// Bus between the route scheduler and its requesters / config writer / network.
//   cfg_*           : configuration table write port
//   req_*           : per-requester route request and one-hot grant (req_ready)
//   o_*_select      : switch selects driven into the Benes interconnect
//   o_window        : one-hot, cycles in which the granted requester drives data
//   o_done/_id      : single-cycle completion pulse and the requester it belongs to
//   o_busy          : scheduler not idle
// slave  = scheduler side, master = requester/environment side.
interface benes_route_scheduler_if
    import fhe_alu_pkg::*;
#(
    parameter int REQ_NUM   = 2,
    parameter int CFG_DEPTH = 16,
    parameter int LEN_W     = 8
);
    localparam int CFG_AW = clog2_min1(CFG_DEPTH);
    localparam int ID_W   = clog2_min1(REQ_NUM);

    logic                              cfg_we;
    logic [CFG_AW-1:0]                 cfg_addr;
    sw_sel_t                           cfg_module_sel;
    sw_sel_t                           cfg_slot_sel;

    logic [REQ_NUM-1:0]                req_valid;
    logic [REQ_NUM-1:0][CFG_AW-1:0]    req_cfg_id;
    logic [REQ_NUM-1:0][LEN_W-1:0]     req_len;
    logic [REQ_NUM-1:0]                req_ready;

    sw_sel_t                           o_module_select;
    sw_sel_t                           o_slot_select;
    logic [REQ_NUM-1:0]                o_window;
    logic                              o_done;
    logic [ID_W-1:0]                   o_done_id;
    logic                              o_busy;

    modport slave (
        input  cfg_we, cfg_addr, cfg_module_sel, cfg_slot_sel,
        input  req_valid, req_cfg_id, req_len,
        output req_ready,
        output o_module_select, o_slot_select, o_window, o_done, o_done_id, o_busy
    );

    modport master (
        output cfg_we, cfg_addr, cfg_module_sel, cfg_slot_sel,
        output req_valid, req_cfg_id, req_len,
        input  req_ready,
        input  o_module_select, o_slot_select, o_window, o_done, o_done_id, o_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   req     : request vector
//   grant   : one-hot grant among asserted requests (combinational)
//   advance : the current grant was taken; next search starts after it
// The pointer resets to requester 0.
module rr_arbiter
    import fhe_alu_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);
    localparam int PW = clog2_min1(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] nxt_ptr;
    logic          found;

    // Pass 0 scans ptr..N-1, pass 1 wraps to 0..ptr-1; first hit wins.
    always_comb begin
        grant   = '0;
        nxt_ptr = ptr_q;
        found   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && ((p == 0) == (j >= int'(ptr_q)))) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    nxt_ptr  = (j == N - 1) ? '0 : PW'(j + 1);
                end
            end
        end
        ptr_d = advance ? nxt_ptr : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/benes_route_scheduler.sv
// Benes route scheduler: grants one requester at a time the shared
// interconnect, drives the stored switch configuration it asked for, opens
// its data window for len cycles, waits NET_LAT cycles for the network to
// drain, then pulses o_done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : benes_route_scheduler_if.slave (config write, requests,
//                grants, selects, window, done, busy)
// Timeline for a grant at cycle T with length L (L = max(req_len,1)):
//   T+1..T+L          APPLY, window high, selects valid from T+1
//   T+L+1..T+L+NET_LAT DRAIN
//   T+L+NET_LAT+1     IDLE, o_done pulse, next grant may happen here
module benes_route_scheduler
    import fhe_alu_pkg::*;
#(
    parameter int REQ_NUM   = 2,
    parameter int CFG_DEPTH = 16,
    parameter int NET_LAT   = 3,
    parameter int LEN_W     = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    benes_route_scheduler_if.slave bus
);
    localparam int CFG_AW = clog2_min1(CFG_DEPTH);
    localparam int ID_W   = clog2_min1(REQ_NUM);
    localparam int NLW    = clog2_min1(NET_LAT + 1);
    localparam int CNT_W  = (LEN_W > NLW) ? LEN_W : NLW;

    route_state_e      state_q, state_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    sw_sel_t           msel_q, msel_d;
    sw_sel_t           ssel_q, ssel_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;

    route_cfg_t        cfg_tbl_q [CFG_DEPTH];

    logic [REQ_NUM-1:0] arb_grant;
    logic               idle_act;
    logic               hs;
    route_req_t         pick;
    logic [ID_W-1:0]    pick_id;

    rr_arbiter #(.N(REQ_NUM)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .grant   (arb_grant),
        .advance (hs)
    );

    // Ready is gated by rst_n too so it drops asynchronously with reset.
    assign idle_act      = (state_q == RS_IDLE) && rst_n;
    assign bus.req_ready = idle_act ? arb_grant : '0;
    assign hs            = idle_act && (|arb_grant);

    // Select the granted requester's fields (grant is one-hot).
    always_comb begin
        pick    = '0;
        pick_id = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (arb_grant[i]) begin
                pick.cfg_id = ROUTE_CFG_AW'(bus.req_cfg_id[i]);
                pick.len    = ROUTE_LEN_W'(bus.req_len[i]);
                pick_id     = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        cnt_d     = cnt_q;
        msel_d    = msel_q;
        ssel_d    = ssel_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        case (state_q)
            RS_IDLE: begin
                if (hs) begin
                    state_d = RS_APPLY;
                    gid_d   = pick_id;
                    // cnt holds remaining APPLY cycles minus one; len 0 acts as 1
                    cnt_d   = (pick.len == '0) ? '0 : CNT_W'(pick.len - 1'b1);
                    // Table read sees pre-write contents if cfg_we hits the same entry now
                    msel_d  = cfg_tbl_q[CFG_AW'(pick.cfg_id)].module_sel;
                    ssel_d  = cfg_tbl_q[CFG_AW'(pick.cfg_id)].slot_sel;
                end
            end
            RS_APPLY: begin
                if (cnt_q == '0) begin
                    if (NET_LAT == 0) begin
                        state_d   = RS_IDLE;
                        done_d    = 1'b1;
                        done_id_d = gid_q;
                    end else begin
                        state_d = RS_DRAIN;
                        cnt_d   = CNT_W'(NET_LAT - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RS_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d   = RS_IDLE;
                    done_d    = 1'b1;
                    done_id_d = gid_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RS_IDLE;
            gid_q     <= '0;
            cnt_q     <= '0;
            msel_q    <= '0;
            ssel_q    <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            gid_q     <= gid_d;
            cnt_q     <= cnt_d;
            msel_q    <= msel_d;
            ssel_q    <= ssel_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    // Configuration table: no reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            cfg_tbl_q[bus.cfg_addr] <= '{module_sel: bus.cfg_module_sel,
                                         slot_sel:   bus.cfg_slot_sel};
        end
    end

    assign bus.o_module_select = msel_q;
    assign bus.o_slot_select   = ssel_q;
    assign bus.o_window        = (state_q == RS_APPLY) ? (REQ_NUM'(1) << gid_q) : '0;
    assign bus.o_done          = done_q;
    assign bus.o_done_id       = done_id_q;
    assign bus.o_busy          = (state_q != RS_IDLE);

endmodule
